fwd_hazard_unit: RTL

//  Parametrised forwarding + load-use hazard unit for the pipelined CPU with cache.

---
 rtl/fwd_pkg.sv | 31 +++
 rtl/fwd_match.sv | 36 +++
 rtl/fwd_hazard_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / load-use hazard unit.
// Shadow entries are packed vectors; the offsets below define their layout.
package fwd_pkg;

   localparam int FWD_SEL_W = 3;
   localparam logic [FWD_SEL_W-1:0] FWD_RF = '0;

   localparam int OFF_VALID = 0;
   localparam int OFF_REGW  = 1;
   localparam int OFF_MEMRD = 2;
   localparam int OFF_RD    = 3;

   function automatic int off_rs(input int reg_w);
      return OFF_RD + reg_w;
   endfunction

   function automatic int off_used(input int num_src, input int reg_w);
      return OFF_RD + reg_w + num_src * reg_w;
   endfunction

   function automatic int entry_w(input int num_src, input int reg_w);
      return off_used(num_src, reg_w) + num_src;
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/fwd_match.sv
// One-operand youngest-writer search over a window of shadow stages.
// o_stage reports the absolute stage index (window position + BASE).
module fwd_match
   import fwd_pkg::*;
#(
   parameter int N     = 2,
   parameter int REG_W = 5,
   parameter int BASE  = 1
) (
   input  logic [REG_W-1:0]       i_rs,
   input  logic                   i_used,
   input  logic [N-1:0]           i_wr,
   input  logic [N*REG_W-1:0]     i_rd,
   input  logic [N-1:0]           i_memread,
   output logic                   o_hit,
   output logic [FWD_SEL_W-1:0]   o_stage,
   output logic                   o_is_load
);

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      o_hit     = 1'b0;
      o_stage   = FWD_RF;
      o_is_load = 1'b0;
      if (i_used && (i_rs != '0)) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (i_wr[k] && (i_rd[k*REG_W +: REG_W] == i_rs)) begin
               o_hit     = 1'b1;
               o_stage   = FWD_SEL_W'(k + BASE);
               o_is_load = i_memread[k];
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with a private shadow pipeline EX..WB.
// Stage 0 is EX; the ID instruction enters stage 0 unless bubbled or flushed.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int NUM_SRC    = 2,
   parameter int REG_W      = 5,
   parameter int LOAD_READY = 2,
   parameter int CNT_W      = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           mem_stall_i,
   input  logic                           flush_i,
   input  logic                           id_valid_i,
   input  logic [NUM_SRC*REG_W-1:0]       id_rs_i,
   input  logic [NUM_SRC-1:0]             id_rs_used_i,
   input  logic [REG_W-1:0]               id_rd_i,
   input  logic                           id_regwrite_i,
   input  logic                           id_memread_i,
   output logic                           stall_o,
   output logic [NUM_SRC*FWD_SEL_W-1:0]   fwd_sel_o,
   output logic [CNT_W-1:0]               stall_count_o
);

   localparam int D      = clamp(DEPTH, 2, 6);
   localparam int LR     = clamp(LOAD_READY, 1, D - 1);
   localparam int ENT_W  = entry_w(NUM_SRC, REG_W);
   localparam int O_RS   = off_rs(REG_W);
   localparam int O_USED = off_used(NUM_SRC, REG_W);
   localparam logic [FWD_SEL_W-1:0] LR_V    = FWD_SEL_W'(LR);
   localparam logic [CNT_W-1:0]     CNT_MAX = '1;

   logic [D-1:0][ENT_W-1:0]        r_ent;
   logic [CNT_W-1:0]               r_cnt;

   logic [ENT_W-1:0]               w_id_ent;
   logic [D-1:0]                   w_wr;
   logic [D-1:0]                   w_ld;
   logic [D*REG_W-1:0]             w_rd;

   logic [NUM_SRC-1:0]                  w_ex_hit;
   logic [NUM_SRC-1:0]                  w_ex_ld;
   logic [NUM_SRC-1:0][FWD_SEL_W-1:0]   w_ex_stage;
   logic [NUM_SRC-1:0]                  w_id_hit;
   logic [NUM_SRC-1:0]                  w_id_ld;
   logic [NUM_SRC-1:0][FWD_SEL_W-1:0]   w_id_stage;
   logic                                w_lu;
   logic                                w_unused_fields;

   always_comb begin
      w_id_ent                            = '0;
      w_id_ent[OFF_VALID]                 = id_valid_i;
      w_id_ent[OFF_REGW]                  = id_regwrite_i;
      w_id_ent[OFF_MEMRD]                 = id_memread_i;
      w_id_ent[OFF_RD +: REG_W]           = id_rd_i;
      w_id_ent[O_RS +: NUM_SRC*REG_W]     = id_rs_i;
      w_id_ent[O_USED +: NUM_SRC]         = id_rs_used_i;
   end

   always_comb begin
      w_wr = '0;
      w_ld = '0;
      w_rd = '0;
      for (int k = 0; k < D; k++) begin
         w_wr[k]               = r_ent[k][OFF_VALID] & r_ent[k][OFF_REGW];
         w_ld[k]               = r_ent[k][OFF_MEMRD];
         w_rd[k*REG_W +: REG_W] = r_ent[k][OFF_RD +: REG_W];
      end
   end

   // Source fields only matter in EX; older stages keep them for completeness.
   assign w_unused_fields = ^r_ent[D-1:1];

   for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
      fwd_match #(.N(D - 1), .REG_W(REG_W), .BASE(1)) u_ex_match (
         .i_rs      (r_ent[0][O_RS + j*REG_W +: REG_W]),
         .i_used    (r_ent[0][OFF_VALID] & r_ent[0][O_USED + j]),
         .i_wr      (w_wr[D-1:1]),
         .i_rd      (w_rd[D*REG_W-1:REG_W]),
         .i_memread (w_ld[D-1:1]),
         .o_hit     (w_ex_hit[j]),
         .o_stage   (w_ex_stage[j]),
         .o_is_load (w_ex_ld[j])
      );

      fwd_match #(.N(D - 1), .REG_W(REG_W), .BASE(0)) u_id_match (
         .i_rs      (id_rs_i[j*REG_W +: REG_W]),
         .i_used    (id_rs_used_i[j]),
         .i_wr      (w_wr[D-2:0]),
         .i_rd      (w_rd[(D-1)*REG_W-1:0]),
         .i_memread (w_ld[D-2:0]),
         .o_hit     (w_id_hit[j]),
         .o_stage   (w_id_stage[j]),
         .o_is_load (w_id_ld[j])
      );
   end

   // A load still short of LOAD_READY cannot be forwarded; the stall keeps it from happening.
   always_comb begin
      fwd_sel_o = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (w_ex_hit[j] && !(w_ex_ld[j] && (w_ex_stage[j] < LR_V)))
            fwd_sel_o[j*FWD_SEL_W +: FWD_SEL_W] = w_ex_stage[j];
      end
   end

   // The load will have moved one stage by the time the ID instruction reaches EX.
   always_comb begin
      w_lu = 1'b0;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (w_id_hit[j] && w_id_ld[j] && ((w_id_stage[j] + FWD_SEL_W'(1)) < LR_V))
            w_lu = 1'b1;
      end
   end

   assign stall_o       = id_valid_i && !flush_i && w_lu;
   assign stall_count_o = r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ent <= '0;
         r_cnt <= '0;
      end else if (!mem_stall_i) begin
         if (flush_i || stall_o)
            r_ent <= {r_ent[D-2:0], {ENT_W{1'b0}}};
         else
            r_ent <= {r_ent[D-2:0], w_id_ent};
         if (stall_o && (r_cnt != CNT_MAX))
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule
